// File: rtl/imem_dmem_loader.sv
// imem_dmem_loader
// Unified instruction/data memory for the multicycle core, with a
// byte-stream program loader in front of it. After reset the block sits in
// LOAD, assembles little-endian bytes into words and writes them from word 0
// upward while holding the core in reset. Once the final byte arrives, or
// the memory is full, it releases the core and serves fetches, loads and
// stores.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   addr_i         instruction byte address from the core
//   inst           registered instruction word
//   addr_d         data byte address from the core
//   wen            data write strobe (honoured only in RUN, word aligned)
//   wdata          store data
//   rdata          registered load data
//   ld_valid       loader byte valid
//   ld_byte        loader byte
//   ld_last        final byte of the program, sampled with ld_valid
//   ld_ready       loader can accept a byte (high in LOAD)
//   core_rst_n     active-low reset to the core, low while loading
//   load_done      high in RUN
//   err_misaligned sticky flag, set by a misaligned core store

module imem_dmem_loader #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 4096,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] addr_i,
  output logic [WORD_LEN-1:0] inst,
  input  logic [WORD_LEN-1:0] addr_d,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                core_rst_n,
  output logic                load_done,
  output logic                err_misaligned
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t              r_state;
  logic [1:0]          r_bcnt;
  logic [IDX_W-1:0]    r_widx;
  logic [WORD_LEN-1:0] r_asm;
  logic                r_ld_ready;
  logic                r_core_rst_n;
  logic                r_load_done;
  logic                r_err;
  logic [WORD_LEN-1:0] r_inst;
  logic [WORD_LEN-1:0] r_rdata;
  logic [WORD_LEN-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]    w_idx_i;
  logic [IDX_W-1:0]    w_idx_d;
  logic                w_accept;
  logic                w_wr_word;
  logic                w_full;
  logic                w_core_wr;
  logic                w_core_mis;
  logic [WORD_LEN-1:0] w_asm_next;
  logic                w_unused;

  // Word indices ignore the byte offset and everything above the array, so
  // addresses wrap modulo the memory size.
  assign w_idx_i = addr_i[IDX_W+1:2];
  assign w_idx_d = addr_d[IDX_W+1:2];
  assign w_unused = ^{addr_i[WORD_LEN-1:IDX_W+2], addr_i[1:0],
                      addr_d[WORD_LEN-1:IDX_W+2]};

  // Loader byte acceptance and word assembly. The assembly register is
  // cleared after every word, so OR-ing the new byte into its lane leaves
  // the unfilled upper bytes zero when ld_last cuts a word short.
  assign w_accept   = !rst && (r_state == LOAD) && ld_valid;
  assign w_asm_next = r_asm | (WORD_LEN'(ld_byte) << {r_bcnt, 3'b000});
  assign w_wr_word  = w_accept && ((r_bcnt == 2'd3) || ld_last);
  assign w_full     = (r_bcnt == 2'd3) && (r_widx == IDX_W'(DEPTH - 1));

  // Core stores only act in RUN; misaligned ones are dropped and flagged.
  assign w_core_wr  = !rst && (r_state == RUN) && wen && (addr_d[1:0] == 2'b00);
  assign w_core_mis = !rst && (r_state == RUN) && wen && (addr_d[1:0] != 2'b00);

  // Single write port shared by loader and core. The two writers can never
  // be active together because they are qualified by opposite FSM states.
  // The array is deliberately not reset so unloaded words keep old data.
  always_ff @(posedge clk) begin
    if (w_wr_word) begin
      r_mem[r_widx] <= w_asm_next;
    end else if (w_core_wr) begin
      r_mem[w_idx_d] <= wdata;
    end
  end

  // Both read ports run every cycle in every state. Non-blocking reads
  // against the write above give read-first behaviour on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= '0;
      r_rdata <= '0;
    end else begin
      r_inst  <= r_mem[w_idx_i];
      r_rdata <= r_mem[w_idx_d];
    end
  end

  // Loader FSM with registered handshake/reset outputs. Leaving LOAD sets
  // the outputs at the same edge the last word is written, so the core is
  // released on the following cycle and never before a word exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_widx       <= '0;
      r_bcnt       <= '0;
      r_asm        <= '0;
      r_ld_ready   <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (ld_last || w_full) begin
              r_state      <= RUN;
              r_bcnt       <= '0;
              r_asm        <= '0;
              r_ld_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_load_done  <= 1'b1;
            end else if (r_bcnt == 2'd3) begin
              r_widx <= r_widx + 1'b1;
              r_bcnt <= '0;
              r_asm  <= '0;
            end else begin
              r_asm  <= w_asm_next;
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  // Sticky misaligned-store flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_core_mis) begin
      r_err <= 1'b1;
    end
  end

  assign inst           = r_inst;
  assign rdata          = r_rdata;
  assign ld_ready       = r_ld_ready;
  assign core_rst_n     = r_core_rst_n;
  assign load_done      = r_load_done;
  assign err_misaligned = r_err;

endmodule

// File: tb/tb_imem_dmem_loader.sv
// Testbench for imem_dmem_loader. A default-depth instance carries most of
// the scenarios; a DEPTH=4 instance sharing the same inputs exercises the
// memory-full auto-release and address wrap.
module tb_imem_dmem_loader;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] addr_d;
  logic        wen;
  logic [31:0] wdata;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;

  logic [31:0] inst, rdata;
  logic        ld_ready, core_rst_n, load_done, err_misaligned;
  logic [31:0] inst4, rdata4;
  logic        ld_ready4, core_rst_n4, load_done4, err_misaligned4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks;
  int   failures;

  imem_dmem_loader dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .inst(inst), .addr_d(addr_d),
    .wen(wen), .wdata(wdata), .rdata(rdata), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .core_rst_n(core_rst_n), .load_done(load_done),
    .err_misaligned(err_misaligned)
  );

  imem_dmem_loader #(.WORD_LEN(32), .DEPTH(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .addr_i(addr_i), .inst(inst4), .addr_d(addr_d),
    .wen(wen), .wdata(wdata), .rdata(rdata4), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready4),
    .core_rst_n(core_rst_n4), .load_done(load_done4),
    .err_misaligned(err_misaligned4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=0", inst); end
    if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
    if (err_misaligned !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err_misaligned); end
    if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_done got=%b exp=0", load_done); end
    if (core_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    if (ld_ready4 !== 1'b1) begin failures++; $display("[TB] FAIL reset_ld_ready4 got=%b exp=1", ld_ready4); end
    rst = 1'b0;
    tick();
    checks++;
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ld_ready got=%b exp=1", ld_ready); end
  endtask

  task automatic test_load_program();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
    for (int i = 0; i < 7; i++) sendByte(prog[i], 1'b0);
    checks += 2;
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL load_ready_before_last got=%b exp=1", ld_ready); end
    if (core_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL load_core_held got=%b exp=0", core_rst_n); end
    sendByte(prog[7], 1'b1);
    checks += 3;
    if (core_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL load_core_release got=%b exp=1", core_rst_n); end
    if (load_done !== 1'b1) begin failures++; $display("[TB] FAIL load_done got=%b exp=1", load_done); end
    if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL load_ready_run got=%b exp=0", ld_ready); end
    sb.push_back('{32'h4, 32'h00a00593});
    sb.push_back('{32'h0, 32'h00500513});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst !== e.data) begin failures++; $display("[TB] FAIL load_inst addr=%h got=%h exp=%h", e.addr, inst, e.data); end
      if (rdata !== e.data) begin failures++; $display("[TB] FAIL load_rdata addr=%h got=%h exp=%h", e.addr, rdata, e.data); end
    end
  endtask

  task automatic test_partial_word();
    doReset();
    for (int i = 1; i <= 5; i++) sendByte(8'(i), (i == 5));
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("[TB] FAIL partial_load_done got=%b exp=1", load_done); end
    sb.push_back('{32'h0, 32'h04030201});
    sb.push_back('{32'h4, 32'h00000005});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst !== e.data) begin failures++; $display("[TB] FAIL partial_inst addr=%h got=%h exp=%h", e.addr, inst, e.data); end
      if (rdata !== e.data) begin failures++; $display("[TB] FAIL partial_rdata addr=%h got=%h exp=%h", e.addr, rdata, e.data); end
    end
  endtask

  task automatic test_store_load();
    addr_d = 32'h100;
    wen    = 1'b1;
    wdata  = 32'h11111111;
    tick();
    wen = 1'b0;
    tick();
    checks++;
    if (rdata !== 32'h11111111) begin failures++; $display("[TB] FAIL store_first got=%h exp=11111111", rdata); end
    wen   = 1'b1;
    wdata = 32'hdeadbeef;
    tick();
    wen = 1'b0;
    checks++;
    if (rdata !== 32'h11111111) begin failures++; $display("[TB] FAIL store_read_first got=%h exp=11111111", rdata); end
    sb.push_back('{32'h100, 32'hdeadbeef});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst !== e.data) begin failures++; $display("[TB] FAIL store_inst addr=%h got=%h exp=%h", e.addr, inst, e.data); end
      if (rdata !== e.data) begin failures++; $display("[TB] FAIL store_rdata addr=%h got=%h exp=%h", e.addr, rdata, e.data); end
    end
  endtask

  task automatic test_misaligned();
    addr_d = 32'h102;
    wen    = 1'b1;
    wdata  = 32'hcafef00d;
    tick();
    wen    = 1'b0;
    addr_d = 32'h100;
    checks++;
    if (err_misaligned !== 1'b1) begin failures++; $display("[TB] FAIL mis_err_set got=%b exp=1", err_misaligned); end
    tick();
    checks++;
    if (rdata !== 32'hdeadbeef) begin failures++; $display("[TB] FAIL mis_no_write got=%h exp=deadbeef", rdata); end
    repeat (3) tick();
    checks++;
    if (err_misaligned !== 1'b1) begin failures++; $display("[TB] FAIL mis_err_sticky got=%b exp=1", err_misaligned); end
    rst = 1'b1;
    tick();
    checks += 3;
    if (err_misaligned !== 1'b0) begin failures++; $display("[TB] FAIL mis_err_clear got=%b exp=0", err_misaligned); end
    if (core_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL run_reset_core got=%b exp=0", core_rst_n); end
    if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL run_reset_done got=%b exp=0", load_done); end
    rst    = 1'b0;
    addr_i = 32'h100;
    tick();
    tick();
    checks++;
    if (inst !== 32'hdeadbeef) begin failures++; $display("[TB] FAIL run_reset_mem_kept got=%h exp=deadbeef", inst); end
    wen   = 1'b1;
    wdata = 32'h12345678;
    tick();
    wen = 1'b0;
    tick();
    checks++;
    if (rdata !== 32'hdeadbeef) begin failures++; $display("[TB] FAIL load_store_ignored got=%h exp=deadbeef", rdata); end
    addr_d = 32'h101;
    wen    = 1'b1;
    tick();
    wen = 1'b0;
    checks++;
    if (err_misaligned !== 1'b0) begin failures++; $display("[TB] FAIL load_mis_ignored got=%b exp=0", err_misaligned); end
  endtask

  task automatic test_reset_midload();
    doReset();
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    doReset();
    sendByte(8'haa, 1'b0);
    tick();
    tick();
    sendByte(8'hbb, 1'b0);
    sendByte(8'hcc, 1'b0);
    tick();
    sendByte(8'hdd, 1'b0);
    checks += 2;
    if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL midload_done got=%b exp=0", load_done); end
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL midload_ready got=%b exp=1", ld_ready); end
    sb.push_back('{32'h0, 32'hddccbbaa});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst !== e.data) begin failures++; $display("[TB] FAIL midload_inst addr=%h got=%h exp=%h", e.addr, inst, e.data); end
      if (rdata !== e.data) begin failures++; $display("[TB] FAIL midload_rdata addr=%h got=%h exp=%h", e.addr, rdata, e.data); end
    end
    sendByte(8'h77, 1'b1);
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("[TB] FAIL midload_last_done got=%b exp=1", load_done); end
    sb.push_back('{32'h4, 32'h00000077});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst !== e.data) begin failures++; $display("[TB] FAIL midload_w1_inst addr=%h got=%h exp=%h", e.addr, inst, e.data); end
      if (rdata !== e.data) begin failures++; $display("[TB] FAIL midload_w1_rdata addr=%h got=%h exp=%h", e.addr, rdata, e.data); end
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] w;
    doReset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checks++;
        if (ld_ready4 !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_before got=%b exp=1", ld_ready4); end
      end
      sendByte(8'h20 + 8'(i), 1'b0);
    end
    checks += 3;
    if (load_done4 !== 1'b1) begin failures++; $display("[TB] FAIL full_done got=%b exp=1", load_done4); end
    if (core_rst_n4 !== 1'b1) begin failures++; $display("[TB] FAIL full_core got=%b exp=1", core_rst_n4); end
    if (ld_ready4 !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_after got=%b exp=0", ld_ready4); end
    for (int k = 0; k < 4; k++) begin
      w = {8'h23 + 8'(4 * k), 8'h22 + 8'(4 * k), 8'h21 + 8'(4 * k), 8'h20 + 8'(4 * k)};
      sb.push_back('{32'h10 + 32'(4 * k), w});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr_i = e.addr;
      addr_d = e.addr;
      tick();
      checks += 2;
      if (inst4 !== e.data) begin failures++; $display("[TB] FAIL wrap_inst addr=%h got=%h exp=%h", e.addr, inst4, e.data); end
      if (rdata4 !== e.data) begin failures++; $display("[TB] FAIL wrap_rdata addr=%h got=%h exp=%h", e.addr, rdata4, e.data); end
    end
  endtask

  // Scenario sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    addr_i   = '0;
    addr_d   = '0;
    wen      = 1'b0;
    wdata    = '0;
    ld_valid = 1'b0;
    ld_byte  = '0;
    ld_last  = 1'b0;
    test_reset();
    test_load_program();
    test_partial_word();
    test_store_load();
    test_misaligned();
    test_reset_midload();
    test_full_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
